spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: sck half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to launch a frame.
REQ-005 SHALL have port rd  input  1  frame type, sampled with start: 1 = read, 0 = write.
REQ-006 SHALL have port addr  input  7  register address, sampled with start.
REQ-007 SHALL have port wdata  input  16  write data, sampled with start.
REQ-008 SHALL have port busy  output  1  high while a frame or the inter-frame gap is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port rdata  output  16  last 16 miso bits of the most recent frame.
REQ-011 SHALL have port sck  output  1  SPI clock; idles high.
REQ-012 SHALL have port mosi  output  1  serial data to slave.
REQ-013 SHALL have port miso  input  1  serial data from slave.
REQ-014 SHALL have port cs  output  1  active-low chip select.

Function
REQ-015 Frame SHALL be 24 bits, MSB first: bit 23 = rd, bits 22:16 = addr, bits 15:0 = wdata (forced to 16'h0000 when rd=1).
REQ-016 Mode SHALL be CPOL=1/CPHA=1: mosi changes only in the cycle sck falls; slave samples on sck rise.
REQ-017 States SHALL be IDLE, SETUP, LOW, HIGH, HOLD, GAP.
REQ-018 IDLE: start=1 SHALL latch rd/addr/wdata, drive cs=0, mosi=bit 23, busy=1 next cycle, enter SETUP.
REQ-019 SETUP SHALL last CLK_DIV cycles with sck=1, then enter LOW.
REQ-020 LOW SHALL last CLK_DIV cycles with sck=0; on entry mosi SHALL present the current bit (bit 23 first).
REQ-021 HIGH SHALL last CLK_DIV cycles with sck=1; miso SHALL be shifted into a 24-bit receive register in the last cycle of HIGH.
REQ-022 A 5-bit bit counter SHALL run 0..23; after HIGH of bit 23 SHALL enter HOLD, else LOW with next bit.
REQ-023 HOLD SHALL last CLK_DIV cycles with cs=0, sck=1, then drive cs=1, update rdata with receive bits 15:0, pulse done, enter GAP.
REQ-024 GAP SHALL last CLK_DIV cycles with cs=1, busy=1, then enter IDLE with busy=0.
REQ-025 Total busy time per frame SHALL be (51*CLK_DIV)+1 cycles from the cycle after start.
REQ-026 start while busy=1 SHALL be ignored with no effect on the frame in progress.
REQ-027 start in the same cycle busy falls SHALL be accepted.
REQ-028 done SHALL pulse for write frames too; rdata SHALL update on every frame.
REQ-029 Outputs SHALL be registered; no combinational path from inputs to sck, mosi, cs.

Reset
REQ-030 rst_n low SHALL immediately force cs=1, sck=1, mosi=0, busy=0, done=0, rdata=16'h0000, state IDLE, counters 0.
REQ-031 Reset mid-frame SHALL abort the frame without a done pulse; the first start after release SHALL begin a clean frame.

Configuration
REQ-032 Macro SPI_MASTER_MISO_SYNC_EN defined: miso SHALL pass a two-flop synchronizer before sampling; CLK_DIV SHALL be >= 3.
REQ-033 Macro SPI_MASTER_MISO_SYNC_EN undefined: miso SHALL be sampled directly; frame timing SHALL be identical in both builds.

Verification
REQ-034 CLK_DIV=2, start with rd=0, addr=7'h05, wdata=16'hBEEF -> mosi bits sampled on sck rises equal 24'h05BEEF; cs low throughout; done after 103 busy cycles.
REQ-035 CLK_DIV=25, rd=1, addr=7'h0A, slave model returns 16'h00AA on last 16 bits -> header 8'h8A on mosi, rdata=16'h00AA at done.
REQ-036 Pulse start during a frame -> frame unchanged, exactly one done, no extra sck edges.
REQ-037 Assert rst_n low after 10 sck rises -> cs=1, sck=1, busy=0 immediately; no done; following frame 24'h05BEEF correct.
REQ-038 Back-to-back: start held high -> cs high for exactly CLK_DIV+1 cycles between frames, 24 sck falls per frame.
REQ-039 Build with SPI_MASTER_MISO_SYNC_EN, CLK_DIV=3, read of addr 7'h03 returning 16'h0033 -> rdata=16'h0033, same cycle count as unsynchronized build.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: register-access SPI master. It sends a 24-bit frame, MSB first,
// in CPOL=1 / CPHA=1 mode: {rd, addr[6:0], wdata[15:0]}, with the data field
// sent as zeros on reads.
// The last 16 miso bits of every frame are presented on rdata, and done pulses
// once per frame.
// Optional build macro SPI_MASTER_MISO_SYNC_EN passes miso through a two-flop
// synchronizer before it is sampled; that build needs CLK_DIV >= 3. Frame
// timing is the same in both builds.
module spi_master #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rd,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    // SETUP runs one cycle longer than the other phases. Its first cycle is
    // the cs-assert cycle, which gives a busy time of 51*CLK_DIV+1.
    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CLK_DIV);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [23:0] tx, tx_nxt;
    logic [23:0] rx, rx_nxt;
    logic        busy_nxt, done_nxt, sck_nxt, mosi_nxt, cs_nxt;
    logic [15:0] rdata_nxt;
    logic        miso_smp;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_meta, miso_sync;

    // Two-flop synchronizer on miso. Its 2-cycle delay fits inside the
    // sck-low half period, so the sample point does not move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    assign miso_smp = miso_sync;
`else
    assign miso_smp = miso;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_cnt <= 5'd0;
            tx      <= 24'h000000;
            rx      <= 24'h000000;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 16'h0000;
            sck     <= 1'b1;
            mosi    <= 1'b0;
            cs      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx      <= tx_nxt;
            rx      <= rx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            rdata   <= rdata_nxt;
            sck     <= sck_nxt;
            mosi    <= mosi_nxt;
            cs      <= cs_nxt;
        end
    end

    // Next-state logic. Output values are computed one cycle ahead, so each
    // output register matches the state it enters.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 8'd1;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx;
        rx_nxt      = rx;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rdata_nxt   = rdata;
        sck_nxt     = sck;
        mosi_nxt    = mosi;
        cs_nxt      = cs;

        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (start) begin
                    state_nxt   = SETUP;
                    tx_nxt      = {rd, addr, (rd ? 16'h0000 : wdata)};
                    bit_cnt_nxt = 5'd0;
                    cs_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    sck_nxt     = 1'b1;
                    mosi_nxt    = rd;
                end
            end

            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = 8'd0;
                    sck_nxt   = 1'b0;
                end
            end

            LOW: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 8'd0;
                    sck_nxt   = 1'b1;
                end
            end

            HIGH: begin
                if (cnt == PHASE_LAST) begin
                    rx_nxt  = {rx[22:0], miso_smp};
                    cnt_nxt = 8'd0;
                    if (bit_cnt == 5'd23) begin
                        state_nxt = HOLD;
                    end else begin
                        // The falling sck edge and the next mosi bit leave together.
                        state_nxt   = LOW;
                        sck_nxt     = 1'b0;
                        tx_nxt      = {tx[22:0], 1'b0};
                        mosi_nxt    = tx[22];
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end

            HOLD: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = 8'd0;
                    cs_nxt    = 1'b1;
                    mosi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    rdata_nxt = rx[15:0];
                end
            end

            GAP: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                    busy_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
                busy_nxt  = 1'b0;
                cs_nxt    = 1'b1;
                sck_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master.
// A behavioural SPI slave drives miso on falling sck edges and captures mosi on
// rising ones. Expected frames, read data and timing come from plain arithmetic.
module tb_spi_master;

`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int DIV = 3;
`else
    localparam int DIV = 2;
`endif
    localparam int BUSY_LEN = 51 * DIV + 1;
    localparam int LIMIT    = 60 * DIV + 40;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rd    = 1'b0;
    logic [6:0]  addr  = 7'd0;
    logic [15:0] wdata = 16'd0;
    logic        miso  = 1'b0;
    logic        busy, done, sck, mosi, cs;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;

    int          falls = 0, rises = 0, dones = 0, cs_err = 0;
    int          fall_base = 0;
    logic [23:0] cap = 24'd0;
    logic [23:0] resp_word = 24'd0;
    logic [15:0] rdata_done = 16'd0;

    spi_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
    );

    always #5 clk = ~clk;

    // Slave transmit: the k-th falling edge of a frame presents response bit 23-k.
    always @(negedge sck) begin
        if ((falls - fall_base) >= 0 && (falls - fall_base) < 24)
            miso = resp_word[23 - (falls - fall_base)];
        falls++;
    end

    // Slave receive: capture mosi on each rising edge and note edges seen with cs high.
    always @(posedge sck) begin
        cap = {cap[22:0], mosi};
        rises++;
        if (cs !== 1'b0) cs_err++;
    end

    // Count done pulses and grab rdata as done appears.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones++;
            rdata_done = rdata;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] model_frame(input logic r, input logic [6:0] a, input logic [15:0] w);
        return {r, a, (r ? 16'h0000 : w)};
    endfunction

    // Run one frame; optionally pulse a conflicting start at busy cycle poke_at.
    task automatic do_frame(input logic r, input logic [6:0] a, input logic [15:0] w,
                            input logic [23:0] resp, input int poke_at,
                            output int blen, output logic [23:0] mos, output int nfall,
                            output int nrise, output int ndone, output int ncserr);
        int f0, r0, d0, c0;
        @(negedge clk);
        resp_word = resp;
        fall_base = falls;
        f0 = falls; r0 = rises; d0 = dones; c0 = cs_err;
        start = 1'b1; rd = r; addr = a; wdata = w;
        @(negedge clk);
        start = 1'b0;
        rd = 1'($urandom); addr = 7'($urandom); wdata = 16'($urandom);
        blen = 0;
        while (busy === 1'b1 && blen < LIMIT) begin
            if (blen == poke_at) begin
                start = 1'b1; rd = ~r; addr = ~a; wdata = ~w;
            end else begin
                start = 1'b0;
            end
            blen++;
            @(negedge clk);
        end
        start = 1'b0;
        mos = cap; nfall = falls - f0; nrise = rises - r0;
        ndone = dones - d0; ncserr = cs_err - c0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 6;
        if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs); end
        if (sck !== 1'b1) begin errors++; $display("FAIL reset_sck got %b want 1", sck); end
        if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int bl, nf, nr, nd, nc;
        logic [23:0] mos, resp;
        resp = 24'($urandom);
        do_frame(1'b0, 7'h05, 16'hBEEF, resp, -1, bl, mos, nf, nr, nd, nc);
        checks += 6;
        if (mos !== 24'h05BEEF) begin errors++; $display("FAIL write_mosi got %h want 05beef", mos); end
        if (bl != BUSY_LEN) begin errors++; $display("FAIL write_busy_len got %0d want %0d", bl, BUSY_LEN); end
        if (nd != 1) begin errors++; $display("FAIL write_done got %0d want 1", nd); end
        if (nf != 24) begin errors++; $display("FAIL write_falls got %0d want 24", nf); end
        if (nc != 0) begin errors++; $display("FAIL write_cs_low got %0d want 0", nc); end
        if (rdata_done !== resp[15:0]) begin errors++; $display("FAIL write_rdata got %h want %h", rdata_done, resp[15:0]); end
    endtask

    task automatic test_read();
        int bl, nf, nr, nd, nc;
        logic [23:0] mos;
        do_frame(1'b1, 7'h0A, 16'h1234, {8'h5C, 16'h00AA}, -1, bl, mos, nf, nr, nd, nc);
        checks += 5;
        if (mos[23:16] !== 8'h8A) begin errors++; $display("FAIL read_header got %h want 8a", mos[23:16]); end
        if (mos[15:0] !== 16'h0000) begin errors++; $display("FAIL read_zero_data got %h want 0000", mos[15:0]); end
        if (rdata_done !== 16'h00AA) begin errors++; $display("FAIL read_rdata_done got %h want 00aa", rdata_done); end
        if (rdata !== 16'h00AA) begin errors++; $display("FAIL read_rdata_hold got %h want 00aa", rdata); end
        if (bl != BUSY_LEN) begin errors++; $display("FAIL read_busy_len got %0d want %0d", bl, BUSY_LEN); end
    endtask

    task automatic test_random();
        int bl, nf, nr, nd, nc;
        logic [23:0] mos, resp, exp;
        logic r;
        logic [6:0] a;
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            r = 1'($urandom); a = 7'($urandom); w = 16'($urandom); resp = 24'($urandom);
            exp = model_frame(r, a, w);
            do_frame(r, a, w, resp, -1, bl, mos, nf, nr, nd, nc);
            checks += 4;
            if (mos !== exp) begin errors++; $display("FAIL rand%0d_mosi got %h want %h", i, mos, exp); end
            if (rdata_done !== resp[15:0]) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", i, rdata_done, resp[15:0]); end
            if (nd != 1) begin errors++; $display("FAIL rand%0d_done got %0d want 1", i, nd); end
            if (bl != BUSY_LEN) begin errors++; $display("FAIL rand%0d_busy_len got %0d want %0d", i, bl, BUSY_LEN); end
        end
    endtask

    task automatic test_ignore_start();
        int bl, nf, nr, nd, nc;
        logic [23:0] mos;
        do_frame(1'b0, 7'h33, 16'hA5C3, 24'h0F0F0F, 20, bl, mos, nf, nr, nd, nc);
        checks += 5;
        if (mos !== 24'h33A5C3) begin errors++; $display("FAIL ignore_mosi got %h want 33a5c3", mos); end
        if (nd != 1) begin errors++; $display("FAIL ignore_done got %0d want 1", nd); end
        if (nf != 24) begin errors++; $display("FAIL ignore_falls got %0d want 24", nf); end
        if (nr != 24) begin errors++; $display("FAIL ignore_rises got %0d want 24", nr); end
        if (bl != BUSY_LEN) begin errors++; $display("FAIL ignore_busy_len got %0d want %0d", bl, BUSY_LEN); end
    endtask

    task automatic test_abort();
        int r0, d0, n, bl, nf, nr, nd, nc;
        logic [23:0] mos;
        @(negedge clk);
        resp_word = 24'hFFFFFF;
        fall_base = falls;
        r0 = rises; d0 = dones;
        start = 1'b1; rd = 1'b0; addr = 7'h7F; wdata = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((rises - r0) < 10 && n < LIMIT) begin n++; @(negedge clk); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (cs !== 1'b1) begin errors++; $display("FAIL abort_cs got %b want 1", cs); end
        if (sck !== 1'b1) begin errors++; $display("FAIL abort_sck got %b want 1", sck); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV + 2) @(negedge clk);
        checks += 1;
        if (dones != d0) begin errors++; $display("FAIL abort_no_done got %0d want %0d", dones, d0); end
        do_frame(1'b0, 7'h05, 16'hBEEF, 24'h00C0DE, -1, bl, mos, nf, nr, nd, nc);
        checks += 3;
        if (mos !== 24'h05BEEF) begin errors++; $display("FAIL abort_next_mosi got %h want 05beef", mos); end
        if (nd != 1) begin errors++; $display("FAIL abort_next_done got %0d want 1", nd); end
        if (bl != BUSY_LEN) begin errors++; $display("FAIL abort_next_busy_len got %0d want %0d", bl, BUSY_LEN); end
    endtask

    task automatic test_back_to_back();
        int n, hi, f0, f1, nf1, nf2;
        logic [23:0] mos1, mos2;
        @(negedge clk);
        resp_word = 24'h123456;
        fall_base = falls;
        f0 = falls;
        start = 1'b1; rd = 1'b0; addr = 7'h05; wdata = 16'hBEEF;
        n = 0;
        while (cs !== 1'b0 && n < LIMIT) begin n++; @(negedge clk); end
        while (cs === 1'b0 && n < 2 * LIMIT) begin n++; @(negedge clk); end
        nf1 = falls - f0; mos1 = cap;
        fall_base = falls; f1 = falls;
        hi = 0;
        while (cs === 1'b1 && hi < LIMIT) begin hi++; @(negedge clk); end
        n = 0;
        while (cs === 1'b0 && n < LIMIT) begin n++; @(negedge clk); end
        start = 1'b0;
        nf2 = falls - f1; mos2 = cap;
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin n++; @(negedge clk); end
        checks += 5;
        if (hi != DIV + 1) begin errors++; $display("FAIL b2b_cs_gap got %0d want %0d", hi, DIV + 1); end
        if (nf1 != 24) begin errors++; $display("FAIL b2b_falls1 got %0d want 24", nf1); end
        if (nf2 != 24) begin errors++; $display("FAIL b2b_falls2 got %0d want 24", nf2); end
        if (mos1 !== 24'h05BEEF) begin errors++; $display("FAIL b2b_mosi1 got %h want 05beef", mos1); end
        if (mos2 !== 24'h05BEEF) begin errors++; $display("FAIL b2b_mosi2 got %h want 05beef", mos2); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
